// File: rtl/fsm_state_guard.sv
// Security monitor for a 4-state control FSM: flags illegal state transitions,
// escalates them into a MON/WARN/LOCK alarm, and reports dwell-limit (stuck) states.
module fsm_state_guard #(
  parameter int unsigned VIOL_LIMIT = 3,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DWELL_MAX  = 1000,
  parameter int unsigned DWELL_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       state_in,
  input  logic             clr_alarm,
  output logic             viol_pulse,
  output logic             alarm,
  output logic             lock,
  output logic             stuck,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [1:0]       last_bad_from,
  output logic [1:0]       last_bad_to
);

  typedef enum logic [1:0] {
    G_MON  = 2'd0,
    G_WARN = 2'd1,
    G_LOCK = 2'd2
  } guard_e;

  localparam logic [1:0]         S1        = 2'b01;
  localparam logic [CNT_W-1:0]   LIMIT     = CNT_W'(VIOL_LIMIT);
  localparam logic [DWELL_W-1:0] DWELL_LIM = DWELL_W'(DWELL_MAX);

  guard_e             state_r, state_next;
  logic [1:0]         prev_r;
  logic               primed_r;
  logic               legal;
  logic               viol;
  logic [CNT_W-1:0]   cnt_next;
  logic               limit_hit;
  logic [DWELL_W-1:0] dwell_r, dwell_next;

  // Legal transition graph; S1 is terminal and may only loop on itself.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    legal = 1'b0;
    case ({prev_r, state_in})
      4'b00_00, 4'b00_01, 4'b00_10,
      4'b01_01,
      4'b10_01, 4'b10_10, 4'b10_11,
      4'b11_10, 4'b11_11: legal = 1'b1;
      default:            legal = 1'b0;
    endcase
  end

  // The first edge after reset only primes prev_r, so it is never checked.
  assign viol      = primed_r && !legal;
  assign cnt_next  = (viol_cnt == '1) ? viol_cnt : viol_cnt + 1'b1;
  assign limit_hit = (cnt_next >= LIMIT);

  always_comb begin
    dwell_next = '0;
    if (primed_r && (state_in == prev_r) && (state_in != S1))
      dwell_next = (dwell_r == DWELL_LIM) ? dwell_r : dwell_r + 1'b1;
  end

  // Guard FSM: state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_r <= G_MON;
    else     state_r <= state_next;
  end

  // Guard FSM: next state (a violation on the same edge overrides clr_alarm)
  always_comb begin
    state_next = state_r;
    case (state_r)
      G_MON:  if (viol) state_next = limit_hit ? G_LOCK : G_WARN;
      G_WARN: begin
        if (viol) begin
          if (limit_hit) state_next = G_LOCK;
        end else if (clr_alarm) begin
          state_next = G_MON;
        end
      end
      G_LOCK:  state_next = G_LOCK;
      default: state_next = G_MON;
    endcase
  end

  // Guard FSM: outputs decoded from the state register
  always_comb begin
    alarm = (state_r != G_MON);
    lock  = (state_r == G_LOCK);
  end

  // Sampling, violation record and dwell tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r        <= 2'b00;
      primed_r      <= 1'b0;
      viol_pulse    <= 1'b0;
      viol_cnt      <= '0;
      last_bad_from <= 2'b00;
      last_bad_to   <= 2'b00;
      dwell_r       <= '0;
      stuck         <= 1'b0;
    end else begin
      prev_r     <= state_in;
      primed_r   <= 1'b1;
      viol_pulse <= viol;
      if (viol) begin
        viol_cnt      <= cnt_next;
        last_bad_from <= prev_r;
        last_bad_to   <= state_in;
      end
      dwell_r <= dwell_next;
      stuck   <= (dwell_next == DWELL_LIM);
    end
  end

endmodule

// File: tb/tb_fsm_state_guard.sv
// Self-checking bench for fsm_state_guard: a rule-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fsm_state_guard;

  localparam int VIOL_LIMIT = 3;
  localparam int CNT_W      = 3;
  localparam int DWELL_MAX  = 8;
  localparam int DWELL_W    = 16;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  // Bit {from,to} set when that transition is legal.
  localparam logic [15:0] LEGAL_MASK = 16'hCE27;

  logic             clk;
  logic             rst;
  logic [1:0]       state_in;
  logic             clr_alarm;
  logic             viol_pulse, alarm, lock, stuck;
  logic [CNT_W-1:0] viol_cnt;
  logic [1:0]       last_bad_from, last_bad_to;

  fsm_state_guard #(
    .VIOL_LIMIT(VIOL_LIMIT), .CNT_W(CNT_W), .DWELL_MAX(DWELL_MAX), .DWELL_W(DWELL_W)
  ) dut (
    .clk(clk), .rst(rst), .state_in(state_in), .clr_alarm(clr_alarm),
    .viol_pulse(viol_pulse), .alarm(alarm), .lock(lock), .stuck(stuck),
    .viol_cnt(viol_cnt), .last_bad_from(last_bad_from), .last_bad_to(last_bad_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = monitoring, 1 = warning, 2 = locked.
  typedef struct {
    bit       primed;
    bit [1:0] prev;
    int       mode;
    int       cnt;
    bit [1:0] from;
    bit [1:0] to;
    bit       pulse;
    int       run;
    bit       stuck;
  } mdl_t;

  function automatic mdl_t next_m(mdl_t m, logic r, logic [1:0] s, logic c);
    mdl_t n;
    bit   bad;
    n = m;
    if (r) begin
      n = '{primed: 0, prev: 0, mode: 0, cnt: 0, from: 0, to: 0, pulse: 0, run: 0, stuck: 0};
      return n;
    end
    bad     = m.primed && !LEGAL_MASK[{m.prev, s}];
    n.pulse = bad;
    if (bad) begin
      n.cnt  = (m.cnt < CNT_MAX) ? m.cnt + 1 : CNT_MAX;
      n.from = m.prev;
      n.to   = s;
      if (m.mode != 2) n.mode = (n.cnt >= VIOL_LIMIT) ? 2 : 1;
    end else if (c && m.mode == 1) begin
      n.mode = 0;
    end
    if (m.primed && s == m.prev && s != 2'b01)
      n.run = (m.run < DWELL_MAX) ? m.run + 1 : DWELL_MAX;
    else
      n.run = 0;
    n.stuck  = (n.run == DWELL_MAX);
    n.prev   = s;
    n.primed = 1;
    return n;
  endfunction

  mdl_t m;
  bit   model_valid = 0;

  always @(posedge clk) begin
    m <= next_m(m, rst, state_in, clr_alarm);
    if (rst) model_valid <= 1'b1;
  end

  // Compare process: DUT against model every cycle once the model is anchored by reset.
  always @(negedge clk) begin
    if (model_valid) begin
      check("viol_pulse", 32'(viol_pulse), 32'(m.pulse));
      check("alarm", 32'(alarm), 32'(m.mode != 0));
      check("lock", 32'(lock), 32'(m.mode == 2));
      check("stuck", 32'(stuck), 32'(m.stuck));
      check("viol_cnt", 32'(viol_cnt), 32'(m.cnt));
      check("last_bad_from", 32'(last_bad_from), 32'(m.from));
      check("last_bad_to", 32'(last_bad_to), 32'(m.to));
    end
  end

  task automatic step(input logic [1:0] s, input logic c, input logic r);
    @(negedge clk);
    state_in  = s;
    clr_alarm = c;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulse"}, 32'(viol_pulse), 0);
    check({tag, "_alarm"}, 32'(alarm), 0);
    check({tag, "_lock"}, 32'(lock), 0);
    check({tag, "_stuck"}, 32'(stuck), 0);
    check({tag, "_cnt"}, 32'(viol_cnt), 0);
  endtask

  logic [1:0] legal_walk [10];
  bit         seen_pulse;

  initial begin
    rst       = 1'b1;
    state_in  = 2'b00;
    clr_alarm = 1'b0;
    legal_walk = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1};

    // 1: legal walk S0,S2,S3,S2,S1
    step(2'd0, 0, 1);
    step(2'd0, 0, 1);
    check_all_zero("reset");
    seen_pulse = 0;
    foreach (legal_walk[i]) begin
      step(legal_walk[i], 0, 0);
      if (viol_pulse) seen_pulse = 1;
    end
    check("t1_no_pulse", 32'(seen_pulse), 0);
    check("t1_alarm", 32'(alarm), 0);
    check("t1_cnt", 32'(viol_cnt), 0);

    // 2: S0 -> S3 is illegal
    step(2'd0, 0, 1);
    step(2'd0, 0, 0);
    step(2'd3, 0, 0);
    check("t2_pulse", 32'(viol_pulse), 1);
    check("t2_from", 32'(last_bad_from), 0);
    check("t2_to", 32'(last_bad_to), 3);
    check("t2_cnt", 32'(viol_cnt), 1);
    check("t2_alarm", 32'(alarm), 1);
    check("t2_lock", 32'(lock), 0);
    step(2'd3, 0, 0);
    check("t2_pulse_once", 32'(viol_pulse), 0);

    // 3: clr_alarm in WARN, then clr_alarm colliding with a violation
    step(2'd3, 1, 0);
    check("t3_cleared", 32'(alarm), 0);
    check("t3_cnt_kept", 32'(viol_cnt), 1);
    step(2'd0, 1, 0);
    check("t3_viol_wins", 32'(alarm), 1);
    check("t3_cnt", 32'(viol_cnt), 2);

    // 4: escalate to LOCK, saturate the counter, reset out of LOCK
    step(2'd1, 0, 0);
    step(2'd0, 0, 0);
    check("t4_lock", 32'(lock), 1);
    check("t4_pulse", 32'(viol_pulse), 1);
    step(2'd1, 0, 0);
    step(2'd0, 0, 0);
    check("t4_cnt4", 32'(viol_cnt), 4);
    step(2'd0, 1, 0);
    check("t4_lock_clr", 32'(lock), 1);
    check("t4_alarm_clr", 32'(alarm), 1);
    step(2'd3, 0, 0);
    step(2'd0, 0, 0);
    step(2'd3, 0, 0);
    step(2'd0, 0, 0);
    check("t4_sat", 32'(viol_cnt), 7);
    check("t4_sat_pulse", 32'(viol_pulse), 1);
    step(2'd3, 0, 1);
    check_all_zero("t4_rst");

    // 5: dwell limit on S3, release on S2, terminal S1 never stuck
    step(2'd3, 0, 0);
    for (int i = 1; i <= DWELL_MAX; i++) begin
      step(2'd3, 0, 0);
      if (i == DWELL_MAX - 1) check("t5_not_yet", 32'(stuck), 0);
    end
    check("t5_stuck", 32'(stuck), 1);
    step(2'd3, 0, 0);
    check("t5_stuck_hold", 32'(stuck), 1);
    check("t5_no_viol", 32'(viol_cnt), 0);
    step(2'd2, 0, 0);
    check("t5_release", 32'(stuck), 0);
    for (int i = 0; i < 50; i++) step(2'd1, 0, 0);
    check("t5_s1", 32'(stuck), 0);

    // 6: reset from WARN, first post-reset sample is never flagged
    step(2'd0, 0, 0);
    check("t6_warn", 32'(alarm), 1);
    step(2'd0, 0, 1);
    step(2'd3, 0, 0);
    check("t6_primed_pulse", 32'(viol_pulse), 0);
    check("t6_primed_cnt", 32'(viol_cnt), 0);
    step(2'd0, 0, 0);
    check("t6_pulse", 32'(viol_pulse), 1);
    check("t6_cnt", 32'(viol_cnt), 1);
    check("t6_from", 32'(last_bad_from), 3);
    check("t6_to", 32'(last_bad_to), 0);

    step(2'd0, 0, 0);
    step(2'd0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
